cla_word_sequencer: RTL

//  Multi-cycle wide adder controller. Accepts WIDTH-bit operands over a valid/ready handshake.

---
 rtl/cla_word_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer: multi-cycle wide adder that walks one 4-bit carry-lookahead slice across the operands, LSB nibble first.
// Optional macro ADDSUB_EN adds a subtract mode (input sub) and a signed-overflow flag (output ovf).
module cla_word_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic                         cin,
`ifdef ADDSUB_EN
  input  logic                         sub,
  output logic                         ovf,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             sum,
  output logic                         cout,
  output logic                         busy,
  output logic [$clog2(WIDTH/4)-1:0]   nib_idx
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic             cin_reg, carry_reg;
  logic [IDX_W+1:0] bit_base;
  logic [3:0]       p, g, s;
  logic             c0, c1, c2, c3, c4;
  logic             last_nib;

  // Nibble 0 takes the latched carry-in; later nibbles take the carry registered from the previous slice.
  always_comb begin
    bit_base = {nib_idx, 2'b00};
    c0       = (nib_idx == '0) ? cin_reg : carry_reg;
    p        = a_reg[bit_base +: 4] ^ b_reg[bit_base +: 4];
    g        = a_reg[bit_base +: 4] & b_reg[bit_base +: 4];
    c1       = g[0] | (p[0] & c0);
    c2       = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3       = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4       = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
    s        = p ^ {c3, c2, c1, c0};
    last_nib = (nib_idx == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_nib) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        busy       = 1'b0;
      end
    endcase
  end

  // Subtraction is folded in at latch time (invert B, force carry-in) so the slice itself only ever adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      cin_reg   <= 1'b0;
      carry_reg <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      nib_idx   <= '0;
`ifdef ADDSUB_EN
      ovf       <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      a_reg   <= a;
`ifdef ADDSUB_EN
      b_reg   <= sub ? ~b : b;
      cin_reg <= sub | cin;
`else
      b_reg   <= b;
      cin_reg <= cin;
`endif
      nib_idx <= '0;
    end else if (state == RUN) begin
      sum[bit_base +: 4] <= s;
      carry_reg          <= c4;
      if (last_nib) begin
        cout    <= c4;
        nib_idx <= '0;
`ifdef ADDSUB_EN
        ovf     <= c3 ^ c4;
`endif
      end else begin
        nib_idx <= nib_idx + 1'b1;
      end
    end
  end

endmodule
